// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: opcode encodings, reorder-buffer geometry and
// the per-entry record held by the reorder buffer.
package tomasulo_pkg;

    localparam int ROB_DEPTH = 8;
    localparam int ROB_IDX_W = 3;
    localparam int DATA_W    = 16;
    localparam int REG_IDX_W = 4;
    localparam int FUNC_W    = 4;
    localparam int COUNT_W   = 4;

    localparam logic [COUNT_W-1:0] ROB_FULL = 4'd8;

    localparam logic [FUNC_W-1:0] OP_ADD   = 4'd0;
    localparam logic [FUNC_W-1:0] OP_SUB   = 4'd1;
    localparam logic [FUNC_W-1:0] OP_AND   = 4'd2;
    localparam logic [FUNC_W-1:0] OP_OR    = 4'd3;
    localparam logic [FUNC_W-1:0] OP_LOAD  = 4'd4;
    localparam logic [FUNC_W-1:0] OP_STORE = 4'd5;
    localparam logic [FUNC_W-1:0] OP_BEQ   = 4'd6;
    localparam logic [FUNC_W-1:0] OP_BNEQ  = 4'd7;

    typedef struct packed {
        logic                 valid;
        logic                 ready;
        logic [FUNC_W-1:0]    func;
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    value;
    } rob_entry_t;

    // Stores and branches retire without touching the register bank.
    function automatic logic writes_regbank(input logic [FUNC_W-1:0] func);
        logic wr;
        case (func)
            OP_STORE: wr = 1'b0;
            OP_BEQ:   wr = 1'b0;
            OP_BNEQ:  wr = 1'b0;
            default:  wr = 1'b1;
        endcase
        return wr;
    endfunction

    function automatic logic is_store_op(input logic [FUNC_W-1:0] func);
        return (func == OP_STORE);
    endfunction

endpackage

// File: rtl/rob_unit.sv
// Eight-entry circular reorder buffer: in-order allocation, out-of-order CDB
// writeback, in-order single retirement per cycle, and full flush on mispredict.
module rob_unit
    import tomasulo_pkg::*;
(
    input  logic                 clk1,
    input  logic                 rst,
    input  logic                 alloc_valid,
    input  logic [FUNC_W-1:0]    alloc_func,
    input  logic [REG_IDX_W-1:0] alloc_rd,
    output logic                 alloc_ready,
    output logic [ROB_IDX_W-1:0] alloc_idx,
    input  logic                 cdb_valid,
    input  logic [ROB_IDX_W-1:0] cdb_idx,
    input  logic [DATA_W-1:0]    cdb_data,
    input  logic [ROB_IDX_W-1:0] rd_idx1,
    input  logic [ROB_IDX_W-1:0] rd_idx2,
    output logic                 rd_ready1,
    output logic                 rd_ready2,
    output logic [DATA_W-1:0]    rd_data1,
    output logic [DATA_W-1:0]    rd_data2,
    input  logic                 flush,
    output logic                 commit_valid,
    output logic [ROB_IDX_W-1:0] commit_idx,
    output logic [REG_IDX_W-1:0] commit_rd,
    output logic [DATA_W-1:0]    commit_data,
    output logic                 commit_wr_en,
    output logic                 commit_is_store,
    output logic [COUNT_W-1:0]   count
);

    rob_entry_t [ROB_DEPTH-1:0] entries_q, entries_d;
    logic [ROB_IDX_W-1:0]       head_q, head_d;
    logic [ROB_IDX_W-1:0]       tail_q, tail_d;
    logic [COUNT_W-1:0]         count_q, count_d;

    logic                       commit_valid_q, commit_valid_d;
    logic [ROB_IDX_W-1:0]       commit_idx_q, commit_idx_d;
    logic [REG_IDX_W-1:0]       commit_rd_q, commit_rd_d;
    logic [DATA_W-1:0]          commit_data_q, commit_data_d;
    logic                       commit_wr_en_q, commit_wr_en_d;
    logic                       commit_is_store_q, commit_is_store_d;

    rob_entry_t                 head_entry;
    logic                       alloc_fire;
    logic                       wb_fire;
    logic                       commit_fire;

    // Full-ness depends only on registered occupancy, never on same-cycle commit.
    assign alloc_ready = (count_q < ROB_FULL);
    assign alloc_idx   = tail_q;
    assign count       = count_q;

    assign head_entry  = entries_q[head_q];
    assign alloc_fire  = alloc_valid && alloc_ready && !flush;
    assign wb_fire     = cdb_valid && entries_q[cdb_idx].valid && !flush;
    assign commit_fire = head_entry.valid && head_entry.ready && !flush;

    // No CDB bypass: lookups see only state captured at previous edges.
    assign rd_ready1 = entries_q[rd_idx1].valid && entries_q[rd_idx1].ready;
    assign rd_ready2 = entries_q[rd_idx2].valid && entries_q[rd_idx2].ready;
    assign rd_data1  = rd_ready1 ? entries_q[rd_idx1].value : 16'd0;
    assign rd_data2  = rd_ready2 ? entries_q[rd_idx2].value : 16'd0;

    assign commit_valid    = commit_valid_q;
    assign commit_idx      = commit_idx_q;
    assign commit_rd       = commit_rd_q;
    assign commit_data     = commit_data_q;
    assign commit_wr_en    = commit_wr_en_q;
    assign commit_is_store = commit_is_store_q;

    // Next-state: writeback, then retirement of head, then allocation at tail.
    always_comb begin
        entries_d         = entries_q;
        head_d            = head_q;
        tail_d            = tail_q;
        count_d           = count_q;
        commit_valid_d    = 1'b0;
        commit_idx_d      = commit_idx_q;
        commit_rd_d       = commit_rd_q;
        commit_data_d     = commit_data_q;
        commit_wr_en_d    = 1'b0;
        commit_is_store_d = 1'b0;

        if (flush) begin
            entries_d = '0;
            head_d    = 3'd0;
            tail_d    = 3'd0;
            count_d   = 4'd0;
        end else begin
            if (wb_fire) begin
                entries_d[cdb_idx].value = cdb_data;
                entries_d[cdb_idx].ready = 1'b1;
            end else begin
                entries_d[cdb_idx] = entries_q[cdb_idx];
            end

            // Retired data comes from the pre-edge value; a same-edge CDB to head is lost with the entry.
            if (commit_fire) begin
                entries_d[head_q] = '0;
                head_d            = head_q + 3'd1;
                commit_valid_d    = 1'b1;
                commit_idx_d      = head_q;
                commit_rd_d       = head_entry.rd;
                commit_data_d     = head_entry.value;
                commit_wr_en_d    = writes_regbank(head_entry.func);
                commit_is_store_d = is_store_op(head_entry.func);
            end else begin
                head_d = head_q;
            end

            if (alloc_fire) begin
                entries_d[tail_q] = '{valid: 1'b1, ready: 1'b0, func: alloc_func,
                                      rd: alloc_rd, value: 16'd0};
                tail_d            = tail_q + 3'd1;
            end else begin
                tail_d = tail_q;
            end

            case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + 4'd1;
                2'b01:   count_d = count_q - 4'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State and retirement registers, cleared asynchronously on rst.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            entries_q         <= '0;
            head_q            <= 3'd0;
            tail_q            <= 3'd0;
            count_q           <= 4'd0;
            commit_valid_q    <= 1'b0;
            commit_idx_q      <= 3'd0;
            commit_rd_q       <= 4'd0;
            commit_data_q     <= 16'd0;
            commit_wr_en_q    <= 1'b0;
            commit_is_store_q <= 1'b0;
        end else begin
            entries_q         <= entries_d;
            head_q            <= head_d;
            tail_q            <= tail_d;
            count_q           <= count_d;
            commit_valid_q    <= commit_valid_d;
            commit_idx_q      <= commit_idx_d;
            commit_rd_q       <= commit_rd_d;
            commit_data_q     <= commit_data_d;
            commit_wr_en_q    <= commit_wr_en_d;
            commit_is_store_q <= commit_is_store_d;
        end
    end

endmodule

// File: tb/tb_rob_unit.sv
// Randomized scoreboard bench for rob_unit against a queue-based program-order model.
module tb_rob_unit;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        alloc_valid = 1'b0;
    logic [3:0]  alloc_func = 4'd0;
    logic [3:0]  alloc_rd = 4'd0;
    logic        alloc_ready;
    logic [2:0]  alloc_idx;
    logic        cdb_valid = 1'b0;
    logic [2:0]  cdb_idx = 3'd0;
    logic [15:0] cdb_data = 16'd0;
    logic [2:0]  rd_idx1 = 3'd0;
    logic [2:0]  rd_idx2 = 3'd0;
    logic        rd_ready1, rd_ready2;
    logic [15:0] rd_data1, rd_data2;
    logic        flush = 1'b0;
    logic        commit_valid;
    logic [2:0]  commit_idx;
    logic [3:0]  commit_rd;
    logic [15:0] commit_data;
    logic        commit_wr_en;
    logic        commit_is_store;
    logic [3:0]  count;

    rob_unit dut (
        .clk1(clk1), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_func(alloc_func), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_data(cdb_data),
        .rd_idx1(rd_idx1), .rd_idx2(rd_idx2),
        .rd_ready1(rd_ready1), .rd_ready2(rd_ready2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .flush(flush),
        .commit_valid(commit_valid), .commit_idx(commit_idx), .commit_rd(commit_rd),
        .commit_data(commit_data), .commit_wr_en(commit_wr_en),
        .commit_is_store(commit_is_store), .count(count)
    );

    always #5 clk1 = ~clk1;

    int edge_cnt = 0;
    always @(posedge clk1) edge_cnt <= edge_cnt + 1;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // Program-order model: front of the queue is the oldest instruction.
    typedef struct {
        logic [2:0]  idx;
        logic [3:0]  func;
        logic [3:0]  rd;
        logic [15:0] val;
        bit          rdy;
    } ment_t;

    typedef struct {
        int          cyc;
        logic [2:0]  idx;
        logic [3:0]  rd;
        logic [15:0] data;
        bit          wr_en;
        bit          is_store;
    } exp_t;

    ment_t mq[$];
    exp_t  exp_q[$];
    int    m_tail = 0;

    task automatic model_lookup(input logic [2:0] idx, output bit rdy, output logic [15:0] d);
        rdy = 1'b0;
        d   = 16'd0;
        foreach (mq[i]) begin
            if (mq[i].idx == idx && mq[i].rdy) begin
                rdy = 1'b1;
                d   = mq[i].val;
            end
        end
    endtask

    task automatic model_step(input bit av, input logic [3:0] af, input logic [3:0] ard,
                              input bit cv, input logic [2:0] ci, input logic [15:0] cd,
                              input bit fl);
        bit do_commit;
        bit do_alloc;
        ment_t e;
        exp_t  x;
        if (fl) begin
            mq.delete();
            m_tail = 0;
        end else begin
            do_commit = (mq.size() > 0) && mq[0].rdy;
            do_alloc  = av && (mq.size() < 8);
            if (do_commit) begin
                e = mq.pop_front();
                x.cyc      = edge_cnt + 1;
                x.idx      = e.idx;
                x.rd       = e.rd;
                x.data     = e.val;
                x.is_store = (e.func == 4'd5);
                x.wr_en    = !(e.func == 4'd5 || e.func == 4'd6 || e.func == 4'd7);
                exp_q.push_back(x);
            end
            if (cv) begin
                foreach (mq[i]) begin
                    if (mq[i].idx == ci) begin
                        mq[i].val = cd;
                        mq[i].rdy = 1'b1;
                    end
                end
            end
            if (do_alloc) begin
                e.idx  = 3'(m_tail);
                e.func = af;
                e.rd   = ard;
                e.val  = 16'd0;
                e.rdy  = 1'b0;
                mq.push_back(e);
                m_tail = (m_tail + 1) % 8;
            end
        end
    endtask

    // One clock: check current state, drive inputs, predict, advance to posedge+1.
    task automatic step(input bit av, input logic [3:0] af, input logic [3:0] ard,
                        input bit cv, input logic [2:0] ci, input logic [15:0] cd,
                        input bit fl);
        bit          er;
        logic [15:0] ed;
        chk("count", count, mq.size());
        chk("alloc_ready", alloc_ready, (mq.size() < 8));
        chk("alloc_idx", alloc_idx, m_tail);
        rd_idx1 = 3'($urandom_range(0, 7));
        rd_idx2 = 3'($urandom_range(0, 7));
        #1;
        model_lookup(rd_idx1, er, ed);
        chk("rd_ready1", rd_ready1, er);
        chk("rd_data1", rd_data1, ed);
        model_lookup(rd_idx2, er, ed);
        chk("rd_ready2", rd_ready2, er);
        chk("rd_data2", rd_data2, ed);
        alloc_valid = av; alloc_func = af; alloc_rd = ard;
        cdb_valid = cv; cdb_idx = ci; cdb_data = cd; flush = fl;
        model_step(av, af, ard, cv, ci, cd, fl);
        @(posedge clk1);
        #1;
        alloc_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 1'b0, 3'd0, 16'd0, 1'b0);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_commit_valid", commit_valid, 1'b0);
        chk("rst_count", count, 4'd0);
        chk("rst_alloc_ready", alloc_ready, 1'b1);
        chk("rst_alloc_idx", alloc_idx, 3'd0);
        chk("rst_commit_idx", commit_idx, 3'd0);
        chk("rst_commit_rd", commit_rd, 4'd0);
        chk("rst_commit_data", commit_data, 16'd0);
        chk("rst_commit_wr_en", commit_wr_en, 1'b0);
        chk("rst_commit_is_store", commit_is_store, 1'b0);
        mq.delete();
        exp_q.delete();
        m_tail = 0;
        @(posedge clk1);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every commit pulse must match the oldest outstanding prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk1);
            if (commit_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_commit", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_cycle", edge_cnt, e.cyc);
                    chk("commit_idx", commit_idx, e.idx);
                    chk("commit_rd", commit_rd, e.rd);
                    chk("commit_data", commit_data, e.data);
                    chk("commit_wr_en", commit_wr_en, e.wr_en);
                    chk("commit_is_store", commit_is_store, e.is_store);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
                chk("missing_commit", 32'd0, 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] ci;
        do_reset();

        // Fill the buffer, then one allocation that must be refused.
        for (int i = 0; i < 8; i++) step(1'b1, 4'd0, 4'(i + 1), 1'b0, 3'd0, 16'd0, 1'b0);
        chk("full_count", count, 4'd8);
        chk("full_alloc_ready", alloc_ready, 1'b0);
        step(1'b1, 4'd0, 4'd9, 1'b0, 3'd0, 16'd0, 1'b0);
        chk("refused_count", count, 4'd8);

        // Out-of-order writeback, in-order retirement.
        step(1'b0, 4'd0, 4'd0, 1'b1, 3'd2, 16'h00AA, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b1, 3'd0, 16'h0011, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b1, 3'd1, 16'h0022, 1'b0);
        idle(3);
        chk("after_ooo_count", count, 4'd5);
        step(1'b0, 4'd0, 4'd0, 1'b0, 3'd0, 16'd0, 1'b1);

        // Full buffer with ready head while alloc is requested.
        for (int i = 0; i < 8; i++) step(1'b1, 4'd1, 4'(i), 1'b0, 3'd0, 16'd0, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b1, 3'd0, 16'h1234, 1'b0);
        step(1'b1, 4'd2, 4'hF, 1'b0, 3'd0, 16'd0, 1'b0);
        chk("full_commit_count", count, 4'd7);
        chk("wrap_alloc_idx", alloc_idx, 3'd0);
        step(1'b1, 4'd2, 4'hE, 1'b0, 3'd0, 16'd0, 1'b0);
        chk("wrap_refill_count", count, 4'd8);
        step(1'b0, 4'd0, 4'd0, 1'b0, 3'd0, 16'd0, 1'b1);

        // Store and branch retirement flags.
        step(1'b1, 4'd5, 4'd3, 1'b0, 3'd0, 16'd0, 1'b0);
        step(1'b1, 4'd6, 4'd5, 1'b0, 3'd0, 16'd0, 1'b0);
        step(1'b1, 4'd7, 4'd2, 1'b0, 3'd0, 16'd0, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b1, 3'd0, 16'h5555, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b1, 3'd1, 16'h0006, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b1, 3'd2, 16'h0007, 1'b0);
        idle(3);

        // Flush racing a CDB write and pending allocations.
        step(1'b0, 4'd0, 4'd0, 1'b0, 3'd0, 16'd0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 4'd0, 4'(i), 1'b0, 3'd0, 16'd0, 1'b0);
        step(1'b1, 4'd0, 4'd4, 1'b1, 3'd0, 16'h0077, 1'b1);
        chk("flush_count", count, 4'd0);
        chk("flush_alloc_idx", alloc_idx, 3'd0);
        chk("flush_commit_valid", commit_valid, 1'b0);
        idle(2);

        // Asynchronous reset with entries in flight.
        for (int i = 0; i < 4; i++)
            step(1'b1, 4'($urandom_range(0, 15)), 4'(i), 1'b0, 3'd0, 16'd0, 1'b0);
        do_reset();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                ci = mq[$urandom_range(0, mq.size() - 1)].idx;
            else
                ci = 3'($urandom_range(0, 7));
            step($urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0, ci, 16'($urandom_range(0, 65535)),
                 $urandom_range(0, 39) == 0);
        end

        idle(3);
        chk("exp_queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
